// File: rtl/bank_lfb_if.sv
// Bank linefill controller bus bundle: miss requests, BIU read channel, linefill buffer
// writes, fill completion, inflight bitmap, error and perf outputs.
interface bank_lfb_if #(
    parameter int IDX_WIDTH  = 6,
    parameter int ADDR_WIDTH = 32
);
    localparam int NLINES = 1 << IDX_WIDTH;

    logic                  miss_valid_i;
    logic                  miss_ready_o;
    logic [IDX_WIDTH-1:0]  miss_idx_i;
    logic [ADDR_WIDTH-1:0] miss_addr_i;

    logic                  biu_ar_valid_o;
    logic                  biu_ar_ready_i;
    logic [IDX_WIDTH-1:0]  biu_ar_id_o;
    logic [ADDR_WIDTH-1:0] biu_ar_addr_o;

    logic                  biu_r_valid_i;
    logic [IDX_WIDTH-1:0]  biu_r_id_i;
    logic                  biu_r_last_i;
    logic [127:0]          biu_r_data_i;

    logic                  lfb_wen_o;
    logic [IDX_WIDTH-1:0]  lfb_waddr_o;
    logic                  lfb_whalf_o;
    logic [127:0]          lfb_wdata_o;

    logic                  fill_done_valid_o;
    logic [IDX_WIDTH-1:0]  fill_done_id_o;
    logic [NLINES-1:0]     inflight_o;
    logic                  err_o;
    logic [31:0]           perf_miss_cnt_o;
    logic [31:0]           perf_dup_cnt_o;
    logic [31:0]           perf_stall_cnt_o;

    // slave: the linefill controller; master: the surrounding bank / test environment
    modport slave (
        input  miss_valid_i, miss_idx_i, miss_addr_i,
        input  biu_ar_ready_i,
        input  biu_r_valid_i, biu_r_id_i, biu_r_last_i, biu_r_data_i,
        output miss_ready_o,
        output biu_ar_valid_o, biu_ar_id_o, biu_ar_addr_o,
        output lfb_wen_o, lfb_waddr_o, lfb_whalf_o, lfb_wdata_o,
        output fill_done_valid_o, fill_done_id_o, inflight_o, err_o,
        output perf_miss_cnt_o, perf_dup_cnt_o, perf_stall_cnt_o
    );

    modport master (
        output miss_valid_i, miss_idx_i, miss_addr_i,
        output biu_ar_ready_i,
        output biu_r_valid_i, biu_r_id_i, biu_r_last_i, biu_r_data_i,
        input  miss_ready_o,
        input  biu_ar_valid_o, biu_ar_id_o, biu_ar_addr_o,
        input  lfb_wen_o, lfb_waddr_o, lfb_whalf_o, lfb_wdata_o,
        input  fill_done_valid_o, fill_done_id_o, inflight_o, err_o,
        input  perf_miss_cnt_o, perf_dup_cnt_o, perf_stall_cnt_o
    );
endinterface

// File: rtl/bank_lfb_ctrl.sv
// Linefill controller for one cache bank: miss FIFO, BIU issue under an outstanding limit,
// two-beat return into the linefill buffer. Optional perf counters: BANK_LFB_PERF_CNT_EN.
module bank_lfb_ctrl #(
    parameter int IDX_WIDTH       = 6,
    parameter int FIFO_PTR_WIDTH  = 3,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_WIDTH      = 32
) (
    input logic       clk_i,
    input logic       rst_ni,
    bank_lfb_if.slave bus
);
    localparam int DEPTH  = 1 << FIFO_PTR_WIDTH;
    localparam int NLINES = 1 << IDX_WIDTH;
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0]        OUT_MAX = OUT_W'(MAX_OUTSTANDING);
    localparam logic [OUT_W-1:0]        OUT_ONE = OUT_W'(1);
    localparam logic [FIFO_PTR_WIDTH:0] PTR_ONE = (FIFO_PTR_WIDTH+1)'(1);

    logic [IDX_WIDTH-1:0]    fifo_idx  [DEPTH];
    logic [ADDR_WIDTH-1:0]   fifo_addr [DEPTH];
    logic [FIFO_PTR_WIDTH:0] wr_ptr, rd_ptr;
    logic                    empty, full;

    logic [OUT_W-1:0]        outstanding;
    logic                    beat_cnt;
    logic [NLINES-1:0]       inflight, inflight_nxt;
    logic                    err;
    logic                    done_vld;
    logic [IDX_WIDTH-1:0]    done_id;

    logic miss_acc, miss_dup, clr_hit, push;
    logic ar_valid, ar_fire;
    logic r_inflight, r_bad, r_good, fill_done;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[FIFO_PTR_WIDTH] != rd_ptr[FIFO_PTR_WIDTH]) &&
                   (wr_ptr[FIFO_PTR_WIDTH-1:0] == rd_ptr[FIFO_PTR_WIDTH-1:0]);

    // Return path: a beat is bad if its line is not inflight or its last flag is out of place
    assign r_inflight = inflight[bus.biu_r_id_i];
    assign r_bad      = bus.biu_r_valid_i &
                        (~r_inflight | (~beat_cnt & bus.biu_r_last_i) | (beat_cnt & ~bus.biu_r_last_i));
    assign r_good     = bus.biu_r_valid_i & ~r_bad;
    assign fill_done  = r_good & beat_cnt;

    // A line completing this cycle is free again, so a miss to it is a fresh request
    assign miss_acc = bus.miss_valid_i & ~full;
    assign clr_hit  = fill_done & (bus.biu_r_id_i == bus.miss_idx_i);
    assign miss_dup = inflight[bus.miss_idx_i] & ~clr_hit;
    assign push     = miss_acc & ~miss_dup;

    assign ar_valid = ~empty & (outstanding < OUT_MAX);
    assign ar_fire  = ar_valid & bus.biu_ar_ready_i;

    always_comb begin
        inflight_nxt = inflight;
        if (fill_done) inflight_nxt[bus.biu_r_id_i] = 1'b0;
        if (push)      inflight_nxt[bus.miss_idx_i] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_idx[i]  <= '0;
                fifo_addr[i] <= '0;
            end
            outstanding <= '0;
            beat_cnt    <= 1'b0;
            inflight    <= '0;
            err         <= 1'b0;
            done_vld    <= 1'b0;
            done_id     <= '0;
        end else begin
            if (push) begin
                fifo_idx[wr_ptr[FIFO_PTR_WIDTH-1:0]]  <= bus.miss_idx_i;
                fifo_addr[wr_ptr[FIFO_PTR_WIDTH-1:0]] <= bus.miss_addr_i;
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (ar_fire) rd_ptr <= rd_ptr + PTR_ONE;

            case ({ar_fire, fill_done && (outstanding != '0)})
                2'b10:   outstanding <= outstanding + OUT_ONE;
                2'b01:   outstanding <= outstanding - OUT_ONE;
                default: outstanding <= outstanding;
            endcase

            // Good beat 0 advances; good beat 1 or any bad beat returns to 0
            if (bus.biu_r_valid_i) beat_cnt <= r_good & ~beat_cnt;

            inflight <= inflight_nxt;
            err      <= err | r_bad;
            done_vld <= fill_done;
            if (fill_done) done_id <= bus.biu_r_id_i;
        end
    end

    assign bus.miss_ready_o      = ~full;
    assign bus.biu_ar_valid_o    = ar_valid;
    assign bus.biu_ar_id_o       = fifo_idx[rd_ptr[FIFO_PTR_WIDTH-1:0]];
    assign bus.biu_ar_addr_o     = fifo_addr[rd_ptr[FIFO_PTR_WIDTH-1:0]];
    assign bus.lfb_wen_o         = r_good;
    assign bus.lfb_waddr_o       = bus.biu_r_id_i;
    assign bus.lfb_whalf_o       = beat_cnt;
    assign bus.lfb_wdata_o       = bus.biu_r_data_i;
    assign bus.fill_done_valid_o = done_vld;
    assign bus.fill_done_id_o    = done_id;
    assign bus.inflight_o        = inflight;
    assign bus.err_o             = err;

`ifdef BANK_LFB_PERF_CNT_EN
    logic [31:0] perf_miss, perf_dup, perf_stall;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_miss  <= '0;
            perf_dup   <= '0;
            perf_stall <= '0;
        end else begin
            if (push && (perf_miss != '1))                 perf_miss  <= perf_miss + 32'd1;
            if (miss_acc && miss_dup && (perf_dup != '1))  perf_dup   <= perf_dup + 32'd1;
            if (ar_valid && !bus.biu_ar_ready_i && (perf_stall != '1))
                perf_stall <= perf_stall + 32'd1;
        end
    end

    assign bus.perf_miss_cnt_o  = perf_miss;
    assign bus.perf_dup_cnt_o   = perf_dup;
    assign bus.perf_stall_cnt_o = perf_stall;
`else
    assign bus.perf_miss_cnt_o  = '0;
    assign bus.perf_dup_cnt_o   = '0;
    assign bus.perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bank_lfb_ctrl.sv
// Scoreboard bench for bank_lfb_ctrl: expected AR requests, buffer writes and fill completions
// are queued at stimulus time and matched as the controller produces them.
module tb_bank_lfb_ctrl;
    localparam int IW = 6;
    localparam int AW = 32;

    typedef struct packed {
        logic          half;
        logic [IW-1:0] id;
        logic [127:0]  data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bank_lfb_if #(.IDX_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();

    bank_lfb_ctrl #(
        .IDX_WIDTH(IW), .FIFO_PTR_WIDTH(3), .MAX_OUTSTANDING(4), .ADDR_WIDTH(AW)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int n_ar = 0, n_miss = 0, n_dup = 0;
    logic [63:0]      model_inflight = '0;
    logic [IW+AW-1:0] exp_ar[$];
    wr_t              exp_wr[$];
    logic [IW-1:0]    exp_fd[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin : mon
        logic [IW+AW-1:0] ea;
        wr_t              ew;
        logic [IW-1:0]    ef;
        if (rst_n) begin
            if (bus.biu_ar_valid_o && bus.biu_ar_ready_i) begin
                n_ar++;
                if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
                else begin
                    ea = exp_ar.pop_front();
                    chk("ar_id",   bus.biu_ar_id_o,   ea[IW+AW-1:AW]);
                    chk("ar_addr", bus.biu_ar_addr_o, ea[AW-1:0]);
                end
            end
            if (bus.lfb_wen_o) begin
                if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    ew = exp_wr.pop_front();
                    chk("wr_half", bus.lfb_whalf_o, ew.half);
                    chk("wr_addr", bus.lfb_waddr_o, ew.id);
                    chk("wr_data", bus.lfb_wdata_o, ew.data);
                end
            end
            if (bus.fill_done_valid_o) begin
                if (exp_fd.size() == 0) chk("fd_unexpected", 1, 0);
                else begin
                    ef = exp_fd.pop_front();
                    chk("fd_id", bus.fill_done_id_o, ef);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic clr_in();
        bus.miss_valid_i  = 1'b0;
        bus.biu_r_valid_i = 1'b0;
        bus.biu_r_last_i  = 1'b0;
    endtask

    task automatic miss_set(input int idx, input logic [31:0] addr);
        bus.miss_valid_i = 1'b1;
        bus.miss_idx_i   = IW'(idx);
        bus.miss_addr_i  = addr;
        if (model_inflight[idx]) n_dup++;
        else begin
            model_inflight[idx] = 1'b1;
            n_miss++;
            exp_ar.push_back({IW'(idx), addr});
        end
    endtask

    task automatic miss(input int idx, input logic [31:0] addr);
        miss_set(idx, addr);
        step();
        clr_in();
    endtask

    task automatic beat_set(input int id, input bit last, input logic [127:0] d, input bit half, input bit ok);
        wr_t w;
        bus.biu_r_valid_i = 1'b1;
        bus.biu_r_id_i    = IW'(id);
        bus.biu_r_last_i  = last;
        bus.biu_r_data_i  = d;
        if (ok) begin
            w.half = half;
            w.id   = IW'(id);
            w.data = d;
            exp_wr.push_back(w);
            if (last) begin
                exp_fd.push_back(IW'(id));
                model_inflight[id] = 1'b0;
            end
        end
    endtask

    task automatic beat(input int id, input bit last, input logic [127:0] d, input bit half, input bit ok);
        beat_set(id, last, d, half, ok);
        if (!ok) begin
            #1;
            chk("err_beat_wen", bus.lfb_wen_o, 0);
        end
        step();
        clr_in();
    endtask

    task automatic fill(input int id);
        beat(id, 1'b0, {64'hD0D0_0000_0000_0000, 64'(id)}, 1'b0, 1'b1);
        beat(id, 1'b1, {64'hD1D1_0000_0000_0000, 64'(id)}, 1'b1, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0;
        logic [31:0] s0;
        clr_in();
        bus.biu_ar_ready_i = 1'b0;
        bus.miss_idx_i     = '0;
        bus.miss_addr_i    = '0;
        bus.biu_r_id_i     = '0;
        bus.biu_r_data_i   = '0;
        s0 = '0;
        idle(3);
        rst_n = 1'b1;
        step();

        // reset state
        chk("rst_ready",    bus.miss_ready_o, 1);
        chk("rst_arv",      bus.biu_ar_valid_o, 0);
        chk("rst_inflight", bus.inflight_o, 0);
        chk("rst_err",      bus.err_o, 0);
        chk("rst_fd",       bus.fill_done_valid_o, 0);
        chk("rst_wen",      bus.lfb_wen_o, 0);
        chk("rst_perf",     {bus.perf_miss_cnt_o, bus.perf_dup_cnt_o, bus.perf_stall_cnt_o}, 0);

        // single miss and fill
        bus.biu_ar_ready_i = 1'b1;
        miss(5, 32'h1000);
        chk("t1_arv",      bus.biu_ar_valid_o, 1);
        chk("t1_arid",     bus.biu_ar_id_o, 5);
        chk("t1_inflight", bus.inflight_o[5], 1);
        idle(2);
        fill(5);
        chk("t1_fd_vld",   bus.fill_done_valid_o, 1);
        chk("t1_infl_clr", bus.inflight_o[5], 0);
        step();
        chk("t1_fd_pulse", bus.fill_done_valid_o, 0);

        // outstanding limit
        a0 = n_ar;
        for (int i = 0; i < 6; i++) miss(10 + i, 32'h2000 + 32'(i * 64));
        idle(8);
        chk("t2_ar4",    n_ar - a0, 4);
        chk("t2_queued", exp_ar.size(), 2);
        fill(10);
        idle(3);
        chk("t2_ar5", n_ar - a0, 5);
        fill(11);
        idle(3);
        chk("t2_ar6", n_ar - a0, 6);
        for (int i = 12; i < 16; i++) fill(i);
        idle(2);

        // back-to-back duplicate
        a0 = n_ar;
        miss(9, 32'h900);
        miss(9, 32'h900);
        idle(3);
        chk("t3_one_ar", n_ar - a0, 1);
        fill(9);
        idle(2);

        // completion and re-miss of the same line in one cycle
        miss(3, 32'h300);
        idle(3);
        a0 = n_ar;
        beat(3, 1'b0, {64'hD0D0_0000_0000_0000, 64'd3}, 1'b0, 1'b1);
        beat_set(3, 1'b1, {64'hD1D1_0000_0000_0000, 64'd3}, 1'b1, 1'b1);
        miss_set(3, 32'h3300);
        step();
        clr_in();
        chk("t4_inflight", bus.inflight_o[3], 1);
        idle(3);
        chk("t4_second_ar", n_ar - a0, 1);
        fill(3);
        idle(2);
        chk("t4_infl_clr", bus.inflight_o[3], 0);

        // FIFO full with BIU stalled
        bus.biu_ar_ready_i = 1'b0;
        a0 = n_ar;
        for (int i = 0; i < 8; i++) miss(20 + i, 32'h5000 + 32'(i * 64));
        chk("t5_not_ready", bus.miss_ready_o, 0);
        chk("t5_arv",       bus.biu_ar_valid_o, 1);
        chk("t5_arid",      bus.biu_ar_id_o, 20);
        s0 = bus.perf_stall_cnt_o;
        idle(5);
        chk("t5_arid_hold", bus.biu_ar_id_o, 20);
`ifdef BANK_LFB_PERF_CNT_EN
        chk("t5_stall_cnt", bus.perf_stall_cnt_o - s0, 5);
`endif
        bus.miss_valid_i = 1'b1;
        bus.miss_idx_i   = IW'(28);
        bus.miss_addr_i  = 32'h7000;
        step();
        clr_in();
        chk("t5_full_drop", bus.inflight_o[28], 0);
        bus.biu_ar_ready_i = 1'b1;
        idle(8);
        chk("t5_ar4", n_ar - a0, 4);
        for (int i = 20; i < 24; i++) fill(i);
        idle(6);
        chk("t5_ar8", n_ar - a0, 8);
        for (int i = 24; i < 28; i++) fill(i);
        idle(2);

`ifdef BANK_LFB_PERF_CNT_EN
        chk("perf_miss", bus.perf_miss_cnt_o, n_miss);
        chk("perf_dup",  bus.perf_dup_cnt_o,  n_dup);
`else
        chk("perf_off", {bus.perf_miss_cnt_o, bus.perf_dup_cnt_o, bus.perf_stall_cnt_o}, 0);
`endif
        chk("q_ar_empty", exp_ar.size(), 0);
        chk("q_wr_empty", exp_wr.size(), 0);
        chk("q_fd_empty", exp_fd.size(), 0);

        // protocol errors
        chk("t6_err_clean", bus.err_o, 0);
        beat(40, 1'b0, 128'hBAD0, 1'b0, 1'b0);
        chk("t6_err_id", bus.err_o, 1);
        miss(41, 32'h4100);
        idle(3);
        beat(41, 1'b1, 128'hBAD1, 1'b0, 1'b0);
        idle(3);
        chk("t6_err_sticky", bus.err_o, 1);
        fill(41);
        idle(2);
        chk("t6_infl_41", bus.inflight_o[41], 0);

        // reset in mid-burst, then a late beat
        miss(42, 32'h4200);
        idle(3);
        beat(42, 1'b0, {64'hD0D0_0000_0000_0000, 64'd42}, 1'b0, 1'b1);
        rst_n = 1'b0;
        #2;
        chk("t7_rst_err",  bus.err_o, 0);
        chk("t7_rst_infl", bus.inflight_o, 0);
        chk("t7_rst_arv",  bus.biu_ar_valid_o, 0);
        model_inflight = '0;
        exp_ar.delete();
        exp_wr.delete();
        exp_fd.delete();
        step();
        rst_n = 1'b1;
        step();
        beat(42, 1'b1, {64'hD1D1_0000_0000_0000, 64'd42}, 1'b1, 1'b0);
        chk("t7_late_err", bus.err_o, 1);
        chk("t7_no_fd",    bus.fill_done_valid_o, 0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
